// File: rtl/dso_cmd_pkg.sv
// ----------------------------------------------------------------------------
// dso_cmd_pkg
// Shared types and constants for the dso command master: the FSM state type,
// the bit layout of a command byte and the register-bus widths.
//   Command byte: bit7 = 1 write / 0 read, bits[6:3] reserved (must be 0),
//                 bits[2:0] register address.
// ----------------------------------------------------------------------------
package dso_cmd_pkg;

  localparam int ADDR_W      = 3;
  localparam int DATA_W      = 8;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_MSB = 6;
  localparam int CMD_RSV_LSB = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,  // waiting for a command byte
    WDATA = 3'd1,  // write command accepted, waiting for the data byte
    WSTB  = 3'd2,  // write strobe cycle towards the register bank
    RSAMP = 3'd3,  // read address settled, capture read data
    RESP  = 3'd4   // presenting the response byte to the host link
  } state_t;

  // A command byte is legal only when its reserved field is all zero.
  function automatic logic cmd_is_legal(input logic [DATA_W-1:0] cmd);
    return cmd[CMD_RSV_MSB:CMD_RSV_LSB] == '0;
  endfunction

endpackage

// File: rtl/dso_cmd_master_if.sv
// ----------------------------------------------------------------------------
// dso_cmd_master_if
// Bundles every non-clock signal of the dso command master:
//   host rx byte link (rx_data/rx_valid/rx_ready),
//   host tx byte link (tx_data/tx_valid/tx_ready),
//   register write port (reg_addr/reg_din/reg_we),
//   register read port (rd_addr/rd_dout),
//   status (err pulse, busy level).
// Modports: master = the command master, slave = host link + register bank.
// ----------------------------------------------------------------------------
interface dso_cmd_master_if;
  import dso_cmd_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_din;
  logic              reg_we;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_dout;

  logic              err;
  logic              busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, rd_dout,
    output rx_ready, tx_data, tx_valid, reg_addr, reg_din, reg_we,
           rd_addr, err, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, rd_dout,
    input  rx_ready, tx_data, tx_valid, reg_addr, reg_din, reg_we,
           rd_addr, err, busy
  );

endinterface

// File: rtl/dso_cmd_master.sv
// ----------------------------------------------------------------------------
// dso_cmd_master
// Parses a byte command stream from a host link and drives the dso register
// bank: write commands take a following data byte and issue a one-cycle
// reg_we; read commands set rd_addr, sample rd_dout and return it as a
// response byte. Illegal commands and a missing write-data byte produce a
// one-cycle err pulse.
// Parameters:
//   TIMEOUT  cycles allowed in WDATA before the write is aborted (1..65535)
//   TW       timer width, 2**TW must exceed TIMEOUT
// Ports:
//   clk      system clock, rising edge
//   nrst     asynchronous active-low reset
//   bus      dso_cmd_master_if.master (host links, register ports, status)
// ----------------------------------------------------------------------------
module dso_cmd_master
  import dso_cmd_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic                    clk,
  input  logic                    nrst,
  dso_cmd_master_if.master        bus
);

  // Last timer value before the abort; the timer starts at 0 on entry to
  // WDATA, so WDATA lasts at most TIMEOUT cycles.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t            state_q,    state_d;
  logic [TW-1:0]     timer_q,    timer_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_din_q,  reg_din_d;
  logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [DATA_W-1:0] tx_data_q,  tx_data_d;
  logic              err_q,      err_d;
  logic              busy_q;

  logic              rx_ready;
  logic              rx_fire;

  // rx_ready is decoded from the state register so it is 1 straight out of
  // reset and can never overlap RESP (where tx_valid is high).
  assign rx_ready = (state_q == IDLE) || (state_q == WDATA);
  assign rx_fire  = bus.rx_valid && rx_ready;

  // --------------------------------------------------------------------------
  // Next-state and datapath updates
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_d    = state_q;
    timer_d    = timer_q;
    reg_addr_d = reg_addr_q;
    reg_din_d  = reg_din_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (!cmd_is_legal(bus.rx_data)) begin
            // Byte is consumed; stay in IDLE and flag it.
            err_d = 1'b1;
          end else if (bus.rx_data[CMD_WR_BIT]) begin
            reg_addr_d = bus.rx_data[ADDR_W-1:0];
            timer_d    = '0;
            state_d    = WDATA;
          end else begin
            rd_addr_d  = bus.rx_data[ADDR_W-1:0];
            state_d    = RSAMP;
          end
        end
      end

      WDATA: begin
        // A data byte arriving on the final timer cycle still wins.
        if (rx_fire) begin
          reg_din_d = bus.rx_data;
          state_d   = WSTB;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      WSTB: begin
        state_d = IDLE;
      end

      RSAMP: begin
        // rd_addr has been stable for a full cycle, so rd_dout is settled.
        tx_data_d = bus.rd_dout;
        state_d   = RESP;
      end

      RESP: begin
        if (bus.tx_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      reg_addr_q <= '0;
      reg_din_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      timer_q    <= timer_d;
      reg_addr_q <= reg_addr_d;
      reg_din_q  <= reg_din_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.rx_ready = rx_ready;
  assign bus.tx_valid = (state_q == RESP);
  assign bus.tx_data  = tx_data_q;
  assign bus.reg_we   = (state_q == WSTB);
  assign bus.reg_addr = reg_addr_q;
  assign bus.reg_din  = reg_din_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_dso_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_dso_cmd_master
// Drives command/data bytes into dso_cmd_master, attaches a simple register
// bank on the write/read ports, and checks every err pulse, register write
// and read response against a transaction-level model through a scoreboard.
// ----------------------------------------------------------------------------
module tb_dso_cmd_master;
  import dso_cmd_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int TW      = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  dso_cmd_master_if bus();

  dso_cmd_master #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Register bank standing in for dso_regw / dso_regr.
  logic [7:0] bank [8];
  always @(posedge clk) if (bus.reg_we) bank[bus.reg_addr] <= bus.reg_din;
  assign bus.rd_dout = bank[bus.rd_addr];

  // ---------------------------------------------------------------- checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  typedef enum int {EV_ERR, EV_WR, EV_RD} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
    int       data;
  } ev_t;

  ev_t exp_q[$];
  int  mdl_mem [8];
  bit  mdl_pending = 0;
  int  mdl_addr    = 0;

  task automatic push_ev(input ev_kind_t k, input int a, input int d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // One host byte, offered 'gap' idle cycles after the previous transfer.
  task automatic model_byte(input logic [7:0] b, input int gap);
    if (mdl_pending) begin
      mdl_pending = 0;
      if (gap < TIMEOUT) begin
        push_ev(EV_WR, mdl_addr, int'(b));
        mdl_mem[mdl_addr] = int'(b);
        return;
      end
      push_ev(EV_ERR, 0, 0);  // write abandoned; byte is parsed as a command
    end
    if (b[6:3] != 4'b0000)  push_ev(EV_ERR, 0, 0);
    else if (b[7]) begin    mdl_pending = 1; mdl_addr = int'(b[2:0]); end
    else                    push_ev(EV_RD, int'(b[2:0]), mdl_mem[b[2:0]]);
  endtask

  // ---------------------------------------------------------------- driver
  // Called and returning at 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    model_byte(b, gap);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (!bus.rx_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("send_accept", bus.rx_ready, 1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  bit rnd_tx = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_tx) bus.tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // --------------------------------------------------------------- monitor
  task automatic expect_ev(input ev_kind_t k, input int a, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", k, 32'hFFFF_FFFF);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", k, e.kind);
    if (k == e.kind && k != EV_ERR) begin
      check(k == EV_WR ? "wr_addr" : "rd_addr", a, e.addr);
      check(k == EV_WR ? "wr_data" : "rd_data", d, e.data);
    end
  endtask

  initial begin
    logic [7:0] prev_tx;
    bit         prev_hold;
    bit         prev_we;
    prev_tx = 0; prev_hold = 0; prev_we = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin prev_hold = 0; prev_we = 0; continue; end
      check("rx_tx_exclusive", bus.rx_ready & bus.tx_valid, 0);
      if (bus.reg_we) begin
        check("we_back_to_back", prev_we, 0);
        check("err_with_we", bus.err, 0);
      end
      if (prev_hold) begin
        check("tx_valid_hold", bus.tx_valid, 1);
        check("tx_data_hold", bus.tx_data, prev_tx);
      end
      if (bus.err)                    expect_ev(EV_ERR, 0, 0);
      if (bus.reg_we)                 expect_ev(EV_WR, int'(bus.reg_addr), int'(bus.reg_din));
      if (bus.tx_valid && bus.tx_ready) expect_ev(EV_RD, int'(bus.rd_addr), int'(bus.tx_data));
      prev_hold = bus.tx_valid && !bus.tx_ready;
      prev_tx   = bus.tx_data;
      prev_we   = bus.reg_we;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] b;
    logic [2:0] a;
    int         r;
    int         n;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bank[i]    = 8'(i * 17);
      mdl_mem[i] = (i * 17) & 8'hFF;
    end

    // Reset state
    #2;
    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_reg_we",   bus.reg_we,   0);
    check("rst_err",      bus.err,      0);
    check("rst_busy",     bus.busy,     0);
    check("rst_reg_addr", bus.reg_addr, 0);
    check("rst_reg_din",  bus.reg_din,  0);
    check("rst_rd_addr",  bus.rd_addr,  0);
    check("rst_tx_data",  bus.tx_data,  0);
    @(posedge clk); @(negedge clk);
    nrst = 1'b1;
    step();

    // 1: write 0xA5 to register 5
    send(8'h85, 0);
    send(8'hA5, 0);
    check("wr_we_latency", bus.reg_we,   1);
    check("wr_reg_addr",   bus.reg_addr, 5);
    check("wr_reg_din",    bus.reg_din,  8'hA5);
    check("wr_err",        bus.err,      0);
    step();
    check("wr_we_single",  bus.reg_we,   0);
    check("bank5",         bank[5],      8'hA5);

    // 2: read register 5 back
    send(8'h05, 0);
    check("rd_cycle1_tx_valid", bus.tx_valid, 0);
    check("rd_cycle1_busy",     bus.busy,     1);
    step();
    check("rd_cycle2_tx_valid", bus.tx_valid, 1);
    check("rd_tx_data",         bus.tx_data,  8'hA5);
    step();
    check("rd_done_busy",       bus.busy,     0);
    check("rd_done_tx_valid",   bus.tx_valid, 0);

    // 3: illegal command, then a normal write
    send(8'h48, 0);
    check("ill_err",      bus.err,      1);
    check("ill_busy",     bus.busy,     0);
    check("ill_rx_ready", bus.rx_ready, 1);
    send(8'h81, 0);
    send(8'h3C, 0);
    step();
    check("bank1",        bank[1],      8'h3C);

    // 4: write-data timeout; the late byte is parsed as a command
    send(8'h82, 0);
    send(8'h11, TIMEOUT + 2);
    check("to_late_byte_err", bus.err,  1);
    check("to_busy",          bus.busy, 0);
    check("to_bank2",         bank[2],  mdl_mem[2]);
    // data byte on the last allowed cycle still writes
    send(8'h82, 0);
    send(8'h5A, TIMEOUT - 1);
    check("to_edge_we",   bus.reg_we,  1);
    check("to_edge_err",  bus.err,     0);
    check("to_edge_din",  bus.reg_din, 8'h5A);

    // 5: backpressure on the response
    bus.tx_ready = 1'b0;
    send(8'h03, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("bp_tx_valid", bus.tx_valid, 1);
      check("bp_tx_data",  bus.tx_data,  mdl_mem[3]);
      check("bp_rx_ready", bus.rx_ready, 0);
      step();
    end
    bus.tx_ready = 1'b1;
    step();
    check("bp_released", bus.tx_valid, 0);
    check("bp_busy",     bus.busy,     0);

    // 6: async reset while the data byte is on offer
    send(8'h87, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h11;
    @(negedge clk);
    nrst = 1'b0;
    mdl_pending = 0;
    #1;
    check("mrst_reg_we",   bus.reg_we,   0);
    check("mrst_tx_valid", bus.tx_valid, 0);
    check("mrst_err",      bus.err,      0);
    check("mrst_busy",     bus.busy,     0);
    check("mrst_reg_addr", bus.reg_addr, 0);
    check("mrst_reg_din",  bus.reg_din,  0);
    check("mrst_rd_addr",  bus.rd_addr,  0);
    check("mrst_tx_data",  bus.tx_data,  0);
    check("mrst_rx_ready", bus.rx_ready, 1);
    bus.rx_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    nrst = 1'b1;
    step();
    send(8'h87, 0);
    send(8'h11, 0);
    check("mrst_wr_we",   bus.reg_we,   1);
    check("mrst_wr_addr", bus.reg_addr, 7);
    step();
    check("bank7",        bank[7],      8'h11);

    // Random traffic with random response backpressure
    rnd_tx = 1;
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 99));
      a = 3'($urandom_range(0, 7));
      if (r < 40) begin
        send({1'b1, 4'b0000, a}, int'($urandom_range(0, 2)));
        send(8'($urandom), int'($urandom_range(0, TIMEOUT + 1)));
      end else if (r < 75) begin
        send({1'b0, 4'b0000, a}, int'($urandom_range(0, 2)));
      end else begin
        b = 8'($urandom);
        if (b[6:3] == 4'b0000) b[4] = 1'b1;
        send(b, int'($urandom_range(0, 2)));
      end
    end
    rnd_tx = 0;
    bus.tx_ready = 1'b1;
    if (mdl_pending) begin
      mdl_pending = 0;
      push_ev(EV_ERR, 0, 0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin step(); n++; end
    repeat (3) step();
    check("scoreboard_drain", exp_q.size(), 0);
    check("final_busy",       bus.busy,     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dso_cmd_master.md
Name: dso_cmd_master

Overview:
- Initiator side of the dso register interface: it parses a byte command stream and drives the write port (addr/din/we) of dso_regw.
- It also drives the read address of dso_regr and returns read data as a response byte.
- It sits between a host byte link (UART/SPI deserializer) and the dso register bank.
- It handles valid/ready handshakes, write-data timeout and illegal-command detection.

Parameters:
TIMEOUT, 255, max cycles spent in WDATA waiting for the data byte before abort (1..65535)
TW, 8, width of timeout counter; must satisfy 2**TW > TIMEOUT

Ports:
clk  in  1  system clock, all logic on posedge
nrst  in  1  asynchronous active-low reset
rx_data  in  8  command/data byte from host link
rx_valid  in  1  rx_data valid
rx_ready  out  1  block accepts rx_data; transfer when rx_valid&&rx_ready at posedge
tx_data  out  8  read response byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  host link accepts tx_data
reg_addr  out  3  write address to dso_regw
reg_din  out  8  write data to dso_regw
reg_we  out  1  write strobe to dso_regw, one-cycle pulse
rd_addr  out  3  read address to dso_regr
rd_dout  in  8  combinational read data from dso_regr
err  out  1  one-cycle error pulse (illegal command or timeout)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (nrst low, async):
  - state=IDLE, timer=0.
  - reg_addr, reg_din, rd_addr, tx_data = 0.
  - reg_we, tx_valid, err = 0; busy=0.
  - rx_ready is state-decoded, so it reads 1 during and after reset.
- Command byte format:
  - bit7 = 1 for write, 0 for read; bits[2:0] = address.
  - bits[6:3] must be 4'b0000. Otherwise the byte is illegal: err pulses the next cycle, state stays IDLE, and the byte is consumed.
- States: IDLE, WDATA, WSTB, RSAMP, RESP.
- IDLE:
  - rx_ready=1.
  - Legal write handshake -> reg_addr<=bits[2:0], timer<=0, go WDATA.
  - Legal read handshake -> rd_addr<=bits[2:0], go RSAMP.
- WDATA:
  - rx_ready=1; timer increments each cycle without a handshake.
  - Handshake -> reg_din<=rx_data, go WSTB.
  - If timer==TIMEOUT-1 and there is no handshake -> err pulse next cycle, go IDLE, no write issued.
  - A handshake in the same cycle as the timeout wins: the write proceeds and there is no err.
- WSTB:
  - rx_ready=0; reg_we=1 for exactly this cycle, with reg_addr/reg_din stable; then IDLE.
  - Write latency: reg_we is high in the cycle after the data-byte handshake.
- RSAMP:
  - rx_ready=0; tx_data<=rd_dout (rd_addr has been stable for a full cycle); go RESP.
- RESP:
  - rx_ready=0, tx_valid=1; tx_data is held constant until tx_ready.
  - tx_valid&&tx_ready -> go IDLE, with tx_valid=0 next cycle.
  - No timeout; backpressure may last indefinitely.
  - Read latency: tx_valid rises 2 cycles after the command handshake.
- Held outputs:
  - reg_addr, reg_din and rd_addr hold their last value outside the states that update them.
  - reg_we is never high for 2 consecutive cycles.
- Pulse and status timing:
  - err is a registered single-cycle pulse and never coincides with reg_we.
  - busy is registered alongside state.
- Throughput:
  - Back-to-back commands: IDLE accepts a new command in the cycle after WSTB or after the RESP handshake.
  - Minimum write period is 3 cycles; minimum read period is 3 cycles with tx_ready held high.
- Reset mid-operation: any state returns immediately to IDLE. A pending write is dropped (no reg_we) and a pending response is dropped (tx_valid=0).
- Protocol invariant: rx_ready and tx_valid are never both high.

Decomposition:
- Package dso_cmd_pkg holds:
  - state enum (state_t);
  - CMD_WR_BIT=7, CMD_RSV_MSB=6, CMD_RSV_LSB=3;
  - ADDR_W=3, DATA_W=8.
- No sub-module is needed: the timeout counter and FSM are small enough to live in one file.
- Top-level integration instantiates dso_cmd_master alongside dso_regw and dso_regr, wiring:
  - reg_addr -> dso_regw.addr, reg_din -> dso_regw.din, reg_we -> dso_regw.we;
  - rd_addr -> dso_regr.addr, dso_regr.dout -> rd_dout.

Test Plan:
1. Write: bytes 8'h85 then 8'hA5 with rx_valid held high -> reg_we high 1 cycle with reg_addr=5, reg_din=8'hA5; with dso_regw attached, reg5==8'hA5 next cycle; err=0.
2. Read: after scenario 1, send 8'h05 with tx_ready=1 -> tx_valid rises 2 cycles after handshake with tx_data=8'hA5; busy returns to 0 the cycle after the tx handshake.
3. Illegal command: send 8'h48 -> err pulses 1 cycle, no reg_we, no tx_valid, state IDLE; next byte 8'h81, 8'h3C writes reg1=8'h3C.
4. Timeout with TIMEOUT=4: send 8'h82, then no data for 4 cycles -> err pulse, busy=0, no reg_we; a later 8'h11 is treated as an illegal command (err), not as data.
5. Backpressure: read 8'h03 with tx_ready=0 for 10 cycles -> tx_valid stays high and tx_data is stable for all 10 cycles, rx_ready=0 throughout; tx_ready=1 -> single transfer.
6. Async reset mid-write: drop nrst during WSTB setup (after data handshake, before the edge) -> reg_we never asserts, all outputs 0, rx_ready=1; the following 8'h87/8'h11 sequence writes normally.
